// File: rtl/flit_demux_ctrl.sv
// Packet-aware 1-to-4 flit demultiplexer with a one-entry output register.
// Optional saturating discard counter on port dropCount, enabled by macro FLIT_DEMUX_DROP_CNT_EN.
module flit_demux_ctrl #(
   parameter int flitWidth = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [flitWidth-1:0] inputFlit,
   input  logic                 inValid,
   output logic                 inReady,
   output logic [flitWidth-1:0] outputFlit1,
   output logic [flitWidth-1:0] outputFlit2,
   output logic [flitWidth-1:0] outputFlit3,
   output logic [flitWidth-1:0] outputFlit4,
   output logic [3:0]           outValid,
   input  logic [3:0]           outReady,
   output logic [1:0]           select,
`ifdef FLIT_DEMUX_DROP_CNT_EN
   output logic [15:0]          dropCount,
`endif
   output logic                 busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } state_t;

   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_BODY = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b11;

   state_t               state_q, state_d;
   logic                 full_q, full_d;
   logic [flitWidth-1:0] flit_q, flit_d;
   logic [1:0]           select_q, select_d;

   logic [1:0]           flit_type_s;
   logic                 accept_s;
   logic                 drain_s;
   logic                 load_s;
   logic                 discard_s;

   assign flit_type_s = inputFlit[flitWidth-1:flitWidth-2];
   assign drain_s     = full_q & outReady[select_q];
   assign inReady     = ~full_q | outReady[select_q];
   assign accept_s    = inValid & inReady;

   // FSM: decides load/discard for the accepted flit and the next packet state
   always_comb begin
      state_d   = state_q;
      select_d  = select_q;
      load_s    = 1'b0;
      discard_s = 1'b0;
      if (accept_s) begin
         case (state_q)
            IDLE: begin
               if (flit_type_s == TYPE_HEAD) begin
                  load_s   = 1'b1;
                  select_d = inputFlit[1:0];
                  state_d  = ROUTE;
               end else begin
                  discard_s = 1'b1;
               end
            end
            ROUTE: begin
               if (flit_type_s == TYPE_BODY) begin
                  load_s = 1'b1;
               end else if (flit_type_s == TYPE_TAIL) begin
                  load_s  = 1'b1;
                  state_d = IDLE;
               end else begin
                  discard_s = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         load_s = 1'b0;
      end
   end

   // Output register: a load wins over a simultaneous drain, so back-to-back flits never bubble
   always_comb begin
      flit_d = flit_q;
      full_d = full_q;
      if (load_s) begin
         flit_d = inputFlit;
         full_d = 1'b1;
      end else if (drain_s) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // State, select and output register flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         full_q   <= 1'b0;
         flit_q   <= {flitWidth{1'b0}};
         select_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         full_q   <= full_d;
         flit_q   <= flit_d;
         select_q <= select_d;
      end
   end

   // Steer the buffered flit to the latched port; all other ports stay zero
   always_comb begin
      outValid    = 4'b0000;
      outputFlit1 = {flitWidth{1'b0}};
      outputFlit2 = {flitWidth{1'b0}};
      outputFlit3 = {flitWidth{1'b0}};
      outputFlit4 = {flitWidth{1'b0}};
      if (full_q) begin
         case (select_q)
            2'd0: begin
               outValid    = 4'b0001;
               outputFlit1 = flit_q;
            end
            2'd1: begin
               outValid    = 4'b0010;
               outputFlit2 = flit_q;
            end
            2'd2: begin
               outValid    = 4'b0100;
               outputFlit3 = flit_q;
            end
            2'd3: begin
               outValid    = 4'b1000;
               outputFlit4 = flit_q;
            end
            default: begin
               outValid = 4'b0000;
            end
         endcase
      end else begin
         outValid = 4'b0000;
      end
   end

   assign select = select_q;
   assign busy   = (state_q == ROUTE);

`ifdef FLIT_DEMUX_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Discard counter saturates rather than wrapping
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (discard_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Discard counter flop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= 16'h0000;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign dropCount = drop_cnt_q;
`else
   logic unused_discard_s;
   assign unused_discard_s = discard_s;
`endif

endmodule

// File: doc/flit_demux_ctrl.md
FLIT_DEMUX_CTRL -- requirements
Module: flit_demux_ctrl

Interface
REQ-001 Parameter flitWidth, default 32: flit width in bits; minimum 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inputFlit  input  flitWidth  incoming flit; [flitWidth-1:flitWidth-2] type (00 invalid, 01 head, 10 body, 11 tail); head [1:0] = destination port.
REQ-005 inValid  input  1  inputFlit valid.
REQ-006 inReady  output  1  controller accepts inputFlit this cycle.
REQ-007 outputFlit1..outputFlit4  output  flitWidth each  demultiplexed flit per port; non-selected ports driven all-zero.
REQ-008 outValid  output  4  per-port valid; bit k maps to outputFlit(k+1).
REQ-009 outReady  input  4  per-port downstream ready.
REQ-010 select  output  2  currently latched destination port.
REQ-011 busy  output  1  high while a packet is in progress (state ROUTE).

Function
REQ-012 Handshake: input transfer occurs when inValid and inReady are both high; output transfer on port k when outValid[k] and outReady[k] are both high.
REQ-013 One-entry output register (flit + full bit); at most one outValid bit high, and only the bit equal to select.
REQ-014 inReady = (!full || outReady[select]) in all states; back-to-back throughput of one flit per cycle.
REQ-015 Latency: an accepted flit appears on the selected output exactly one cycle after acceptance.
REQ-016 FSM states IDLE, ROUTE; reset state IDLE.
REQ-017 IDLE, head accepted: select <= inputFlit[1:0], flit loaded into output register, next state ROUTE.
REQ-018 IDLE, body/tail/invalid accepted: flit discarded, output register unchanged, state stays IDLE.
REQ-019 ROUTE, body accepted: loaded into output register, state stays ROUTE.
REQ-020 ROUTE, tail accepted: loaded into output register, next state IDLE; select holds until the next head.
REQ-021 ROUTE, head or invalid-type accepted: discarded, state stays ROUTE.
REQ-022 Head accepted in IDLE in the same cycle a previous tail drains: load and drain both take effect; no bubble.
REQ-023 Register drained with no new load: full clears the next cycle.
REQ-024 select changes only on head acceptance in IDLE; never while full is set with a different destination pending.

Reset
REQ-025 On reset assertion, immediately: state IDLE, full 0, outValid 4'b0000, select 2'b00, busy 0, all outputFlit zero, drop counter 0.
REQ-026 Reset mid-packet discards the buffered flit and in-progress packet; no partial output after deassertion.
REQ-027 inReady is 1 during and after reset (register empty).

Configuration
REQ-028 Macro FLIT_DEMUX_DROP_CNT_EN: when defined, an extra output dropCount (16 bits) counts every discarded flit (REQ-018, REQ-021), saturating at 16'hFFFF.
REQ-029 Without FLIT_DEMUX_DROP_CNT_EN, port dropCount and its logic are absent; discard behaviour is unchanged.

Verification
REQ-030 Head dest 2, body, tail, all outReady=1 -> outValid=4'b0100 on cycles 1-3 after each accept, outputFlit3 equals each flit, busy falls after tail acceptance.
REQ-031 Packet to port 1 with outReady[1]=0 for 3 cycles -> flit held on outputFlit2, inReady=0 until outReady[1]=1, no flit lost or duplicated.
REQ-032 Tail to port 0 immediately followed by head to port 3 with continuous ready -> no idle cycle; outValid 4'b0001 then 4'b1000.
REQ-033 Body flit in IDLE, then head during ROUTE -> both discarded, outValid stays 0 for them, dropCount=2 with FLIT_DEMUX_DROP_CNT_EN.
REQ-034 Reset asserted mid-packet with register full -> outValid=0 and busy=0 asynchronously; following body flit discarded in IDLE.
REQ-035 300 000 discarded flits with FLIT_DEMUX_DROP_CNT_EN -> dropCount saturates at 16'hFFFF.
